// File: rtl/demux_2_buf.sv
// demux_2_buf: one input stream steered by SEL into one of two FIFOs.
// Each FIFO has its own valid/ready consumer interface.
//
// Parameters:
//   WIDTH  data word width
//   DEPTH  entries per FIFO (power of two, >= 2)
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   SEL, DAT_IN, IN_VALID    input word and its route (0 -> FIFO 0, 1 -> FIFO 1)
//   IN_READY                 selected FIFO can take a word (combinational on SEL)
//   DAT_OUT_k, OUT_VALID_k   head word of FIFO k (zero when empty), non-empty flag
//   OUT_READY_k              consumer k takes the head word
//   LVL_k                    FIFO k occupancy, 0..DEPTH
//   CNT_k                    16-bit push counters, present only when the
//                            DEMUX_2_CNT_EN macro is defined
module demux_2_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     SEL,
    input  logic [WIDTH-1:0]         DAT_IN,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    output logic [WIDTH-1:0]         DAT_OUT_0,
    output logic [WIDTH-1:0]         DAT_OUT_1,
    output logic                     OUT_VALID_0,
    output logic                     OUT_VALID_1,
    input  logic                     OUT_READY_0,
    input  logic                     OUT_READY_1,
    output logic [$clog2(DEPTH):0]   LVL_0,
    output logic [$clog2(DEPTH):0]   LVL_1
`ifdef DEMUX_2_CNT_EN
    ,
    output logic [15:0]              CNT_0,
    output logic [15:0]              CNT_1
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [1:0]            full;
    logic [1:0]            vld;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            ordy;
    logic [1:0][WIDTH-1:0] head;
    logic [1:0][LW-1:0]    lvl;

    assign ordy = {OUT_READY_1, OUT_READY_0};

    // While RST is high the FIFOs are about to be cleared, so report ready
    // as if empty. Pushes in that cycle are discarded by the reset branch.
    assign IN_READY = RST | ~full[SEL];

    assign push[0] = IN_VALID & IN_READY & ~SEL;
    assign push[1] = IN_VALID & IN_READY & SEL;
    // A pop only happens on a non-empty FIFO, so LVL cannot underflow.
    assign pop     = vld & ordy;

    for (genvar k = 0; k < 2; k++) begin : g_fifo
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wptr;
        logic [AW-1:0]    rptr;
        logic [LW-1:0]    lvl_q;
        logic [LW-1:0]    lvl_nxt;
        logic             valid_q;

        always_comb begin
            lvl_nxt = lvl_q;
            if (push[k] && !pop[k])
                lvl_nxt = lvl_q + 1'b1;
            else if (pop[k] && !push[k])
                lvl_nxt = lvl_q - 1'b1;
        end

        // Storage is not reset; stale entries are unreachable once the
        // pointers and level are cleared.
        always_ff @(posedge CLK) begin
            if (push[k])
                mem[wptr] <= DAT_IN;
        end

        // Pointers are AW bits wide, so increment wraps DEPTH-1 -> 0.
        always_ff @(posedge CLK) begin
            if (RST) begin
                wptr    <= '0;
                rptr    <= '0;
                lvl_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                if (push[k])
                    wptr <= wptr + 1'b1;
                if (pop[k])
                    rptr <= rptr + 1'b1;
                lvl_q   <= lvl_nxt;
                valid_q <= (lvl_nxt != '0);
            end
        end

        assign full[k] = (lvl_q == LW'(DEPTH));
        assign vld[k]  = valid_q;
        assign lvl[k]  = lvl_q;
        assign head[k] = valid_q ? mem[rptr] : '0;
    end

    assign DAT_OUT_0   = head[0];
    assign DAT_OUT_1   = head[1];
    assign OUT_VALID_0 = vld[0];
    assign OUT_VALID_1 = vld[1];
    assign LVL_0       = lvl[0];
    assign LVL_1       = lvl[1];

`ifdef DEMUX_2_CNT_EN
    logic [1:0][15:0] cnt;

    for (genvar k = 0; k < 2; k++) begin : g_cnt
        logic [15:0] cnt_q;

        // Free-running push count, wraps 65535 -> 0.
        always_ff @(posedge CLK) begin
            if (RST)
                cnt_q <= '0;
            else if (push[k])
                cnt_q <= cnt_q + 16'd1;
        end

        assign cnt[k] = cnt_q;
    end

    assign CNT_0 = cnt[0];
    assign CNT_1 = cnt[1];
`endif

endmodule

// File: tb/tb_demux_2_buf.sv
// Self-checking bench for demux_2_buf (WIDTH=32, DEPTH=4).
// Directed vector table + random traffic, both checked against a
// queue-based reference model.
module tb_demux_2_buf;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             SEL = 1'b0;
    logic [WIDTH-1:0] DAT_IN = '0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [WIDTH-1:0] DAT_OUT_0, DAT_OUT_1;
    logic             OUT_VALID_0, OUT_VALID_1;
    logic             OUT_READY_0 = 1'b0;
    logic             OUT_READY_1 = 1'b0;
    logic [2:0]       LVL_0, LVL_1;
`ifdef DEMUX_2_CNT_EN
    logic [15:0]      CNT_0, CNT_1;
`endif

    demux_2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .SEL(SEL), .DAT_IN(DAT_IN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .DAT_OUT_0(DAT_OUT_0), .DAT_OUT_1(DAT_OUT_1),
        .OUT_VALID_0(OUT_VALID_0), .OUT_VALID_1(OUT_VALID_1),
        .OUT_READY_0(OUT_READY_0), .OUT_READY_1(OUT_READY_1),
        .LVL_0(LVL_0), .LVL_1(LVL_1)
`ifdef DEMUX_2_CNT_EN
        , .CNT_0(CNT_0), .CNT_1(CNT_1)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per output, plus push counters.
    logic [31:0] mq0[$];
    logic [31:0] mq1[$];
    logic [15:0] mc0 = 16'd0;
    logic [15:0] mc1 = 16'd0;

    typedef struct {
        logic        rst, sel;
        logic [31:0] din;
        logic        iv, r0, r1;
        logic        e_rdy;
        logic        e_v0;
        logic [31:0] e_d0;
        logic [2:0]  e_l0;
        logic        e_v1;
        logic [31:0] e_d1;
        logic [2:0]  e_l1;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic rst, logic sel, logic [31:0] din, logic iv,
                                logic r0, logic r1, logic e_rdy,
                                logic e_v0, logic [31:0] e_d0, logic [2:0] e_l0,
                                logic e_v1, logic [31:0] e_d1, logic [2:0] e_l1);
        vec_t v;
        v.rst = rst; v.sel = sel; v.din = din; v.iv = iv; v.r0 = r0; v.r1 = r1;
        v.e_rdy = e_rdy;
        v.e_v0 = e_v0; v.e_d0 = e_d0; v.e_l0 = e_l0;
        v.e_v1 = e_v1; v.e_d1 = e_d1; v.e_l1 = e_l1;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle: check IN_READY before the edge, advance the model
    // with the rules of the block, then check all outputs after the edge.
    task automatic apply(input logic rst, input logic sel, input logic [31:0] din,
                         input logic iv, input logic r0, input logic r1,
                         output logic rdy_s);
        logic p0, p1, ps, full_sel;
        RST = rst; SEL = sel; DAT_IN = din; IN_VALID = iv;
        OUT_READY_0 = r0; OUT_READY_1 = r1;
        #1;
        full_sel = sel ? (mq1.size() >= DEPTH) : (mq0.size() >= DEPTH);
        rdy_s = IN_READY;
        chk("in_ready", {63'd0, IN_READY}, {63'd0, rst | ~full_sel});
        p0 = r0 && (mq0.size() > 0);
        p1 = r1 && (mq1.size() > 0);
        ps = iv && !full_sel;
        @(posedge CLK);
        if (rst) begin
            mq0.delete(); mq1.delete();
            mc0 = 16'd0; mc1 = 16'd0;
        end else begin
            if (p0) void'(mq0.pop_front());
            if (p1) void'(mq1.pop_front());
            if (ps) begin
                if (sel) begin mq1.push_back(din); mc1 = mc1 + 16'd1; end
                else     begin mq0.push_back(din); mc0 = mc0 + 16'd1; end
            end
        end
        #1;
        chk("out_valid_0", {63'd0, OUT_VALID_0}, {63'd0, mq0.size() > 0});
        chk("out_valid_1", {63'd0, OUT_VALID_1}, {63'd0, mq1.size() > 0});
        chk("dat_out_0", {32'd0, DAT_OUT_0}, {32'd0, (mq0.size() > 0) ? mq0[0] : 32'd0});
        chk("dat_out_1", {32'd0, DAT_OUT_1}, {32'd0, (mq1.size() > 0) ? mq1[0] : 32'd0});
        chk("lvl_0", {61'd0, LVL_0}, 64'(mq0.size()));
        chk("lvl_1", {61'd0, LVL_1}, 64'(mq1.size()));
`ifdef DEMUX_2_CNT_EN
        chk("cnt_0", {48'd0, CNT_0}, {48'd0, mc0});
        chk("cnt_1", {48'd0, CNT_1}, {48'd0, mc1});
`endif
    endtask

    initial begin
        logic rdy;
        // Reset then single push to output 0.
        add(1,0,0,0,0,0, 1, 0,0,0, 0,0,0);
        add(0,0,207,1,0,0, 1, 1,207,1, 0,0,0);
        add(0,0,0,0,1,0, 1, 0,0,0, 0,0,0);
        // Alternate SEL 1,0,1 with 15,31,9, then pop both.
        add(0,1,15,1,0,0, 1, 0,0,0, 1,15,1);
        add(0,0,31,1,0,0, 1, 1,31,1, 1,15,1);
        add(0,1,9,1,0,0,  1, 1,31,1, 1,15,2);
        add(0,0,0,0,1,1,  1, 0,0,0, 1,9,1);
        add(0,0,0,0,0,1,  1, 0,0,0, 0,0,0);
        // Stall output 0 and fill it; fifth word held.
        add(0,0,1,1,0,0, 1, 1,1,1, 0,0,0);
        add(0,0,2,1,0,0, 1, 1,1,2, 0,0,0);
        add(0,0,3,1,0,0, 1, 1,1,3, 0,0,0);
        add(0,0,4,1,0,0, 1, 1,1,4, 0,0,0);
        add(0,0,5,1,0,0, 0, 1,1,4, 0,0,0);
        // Other output still accepts.
        add(0,1,2,1,0,0, 1, 1,1,4, 1,2,1);
        // Full FIFO 0: pop and push together -> push refused.
        add(0,0,5,1,1,0, 0, 1,2,3, 1,2,1);
        add(0,0,5,1,0,0, 1, 1,2,4, 1,2,1);
        // 10 push/pop pairs on FIFO 1 at steady level 1 (pointers wrap).
        for (int i = 0; i < 10; i++)
            add(0,1,100+i,1,0,1, 1, 1,2,4, 1,100+i,1);
        // Drain one from FIFO 0, then reset with level 3.
        add(0,0,0,0,1,0, 0, 1,3,3, 1,109,1);
        add(1,0,66,1,1,1, 1, 0,0,0, 0,0,0);
        // First post-reset push is first out.
        add(0,0,77,1,0,0, 1, 1,77,1, 0,0,0);
        add(0,0,0,0,1,0, 1, 0,0,0, 0,0,0);

        @(posedge CLK); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].sel, tbl[i].din, tbl[i].iv, tbl[i].r0, tbl[i].r1, rdy);
            chk($sformatf("vec%0d_rdy", i), {63'd0, rdy}, {63'd0, tbl[i].e_rdy});
            chk($sformatf("vec%0d_v0", i), {63'd0, OUT_VALID_0}, {63'd0, tbl[i].e_v0});
            chk($sformatf("vec%0d_d0", i), {32'd0, DAT_OUT_0}, {32'd0, tbl[i].e_d0});
            chk($sformatf("vec%0d_l0", i), {61'd0, LVL_0}, {61'd0, tbl[i].e_l0});
            chk($sformatf("vec%0d_v1", i), {63'd0, OUT_VALID_1}, {63'd0, tbl[i].e_v1});
            chk($sformatf("vec%0d_d1", i), {32'd0, DAT_OUT_1}, {32'd0, tbl[i].e_d1});
            chk($sformatf("vec%0d_l1", i), {61'd0, LVL_1}, {61'd0, tbl[i].e_l1});
        end

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 99) == 0, 1'($urandom), $urandom,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, rdy);
        end

`ifdef DEMUX_2_CNT_EN
        // Counter wrap: 65536 pushes to output 0 bring CNT_0 back to 0.
        apply(1,0,0,0,0,0, rdy);
        for (int i = 0; i < 65536; i++)
            apply(0,0,i,1,1,0, rdy);
        chk("cnt_0_wrap", {48'd0, CNT_0}, 64'd0);
        chk("cnt_1_idle", {48'd0, CNT_1}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
